// File: rtl/mux_arb.sv
// mux_arb: N-channel, W-bit arbitrating multiplexer with a registered output and valid/ready handshakes.
// Ports: clk, rst (synchronous, active-high); in_data[N*W], in_valid[N], in_ready[N] per producer;
//        out_data[W], out_sel[SW], out_valid, out_ready towards the single consumer.
// Define MUX_ARB_RR_EN for round-robin arbitration; left undefined, the lowest-index valid channel wins.
module mux_arb #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N*W-1:0]         in_data,
    input  logic [N-1:0]           in_valid,
    output logic [N-1:0]           in_ready,
    output logic [W-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(N)-1:0]   out_sel
);
    localparam int SW = $clog2(N);
    logic [SW-1:0] ptr, g_hi, g_lo, g;
    logic hit_hi, any, load_en;
    assign load_en = !out_valid || out_ready;
    // First valid channel at or above ptr wins; if none, wrap to the lowest valid channel.
    always_comb begin
        g_hi = '0;
        g_lo = '0;
        hit_hi = 1'b0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                g_lo = SW'(i);
                any = 1'b1;
                if (i >= int'(ptr)) begin
                    g_hi = SW'(i);
                    hit_hi = 1'b1;
                end
            end
        end
    end
    assign g = hit_hi ? g_hi : g_lo;
    assign in_ready = (!rst && load_en && any) ? N'(1) << g : '0;
`ifdef MUX_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else if (load_en && any)
            ptr <= (int'(g) == N - 1) ? '0 : g + 1'b1;
    end
`else
    assign ptr = '0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_sel <= '0;
        end else if (load_en) begin
            out_valid <= any;
            if (any) begin
                out_data <= in_data[g*W +: W];
                out_sel <= g;
            end
        end
    end
endmodule

// File: tb/tb_mux_arb.sv
// tb_mux_arb: directed scoreboard bench for mux_arb (N=4 and N=3 instances, W=8).
module tb_mux_arb;
    localparam int W = 8;
`ifdef MUX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4*W-1:0] in_data;
    logic [3:0]     in_valid, in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid, out_ready;
    logic [1:0]     out_sel;

    logic [3*W-1:0] d3;
    logic [2:0]     v3, rdy3;
    logic [W-1:0]   od3;
    logic           ov3, or3;
    logic [1:0]     os3;

    int checks = 0;
    int errors = 0;
    logic [9:0] q4[$];
    logic [9:0] q3[$];
    int s;

    mux_arb #(.N(4), .W(W)) u4 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel)
    );

    mux_arb #(.N(3), .W(W)) u3 (
        .clk(clk), .rst(rst), .in_data(d3), .in_valid(v3), .in_ready(rdy3),
        .out_data(od3), .out_valid(ov3), .out_ready(or3), .out_sel(os3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Monitors: every consumed output word must match the oldest expected {sel,data}.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out4_unexpected: got %0h expected none", {out_sel, out_data});
            end else
                chk("out4", {22'b0, out_sel, out_data}, {22'b0, q4.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && ov3 && or3) begin
            if (q3.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out3_unexpected: got %0h expected none", {os3, od3});
            end else
                chk("out3", {22'b0, os3, od3}, {22'b0, q3.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        in_valid = 4'b1111;
        out_ready = 1'b1;
        d3 = {8'h22, 8'h21, 8'h20};
        v3 = 3'b000;
        or3 = 1'b1;
        // Reset with every channel offering a word
        repeat (2) begin
            step();
            #1;
            chk("rst_rdy", in_ready, 4'b0000);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_sel", out_sel, 0);
        end
        rst = 1'b0;
        #1;
        // Fairness: all channels valid, consumer always ready
        for (int k = 0; k < 6; k++) begin
            s = RR ? k % 4 : 0;
            chk("fair_rdy", in_ready, 4'b1 << s);
            q4.push_back({2'(s), 8'(8'h10 + s)});
            step();
            #1;
        end
        chk("fair_valid", out_valid, 1);
        in_valid = 4'b0000;
        #1;
        chk("idle_rdy", in_ready, 4'b0000);
        step();
        #1;
        chk("drain_valid", out_valid, 0);
        // Single channel
        in_valid = 4'b0100;
        in_data[2*W +: W] = 8'hA5;
        #1;
        chk("single_rdy", in_ready, 4'b0100);
        q4.push_back({2'd2, 8'hA5});
        step();
        in_valid = 4'b0000;
        #1;
        chk("single_valid", out_valid, 1);
        chk("single_sel", out_sel, 2);
        chk("single_data", out_data, 8'hA5);
        step();
        #1;
        chk("single_drain", out_valid, 0);
        // Backpressure
        in_valid = 4'b0010;
        in_data[W +: W] = 8'h3C;
        #1;
        chk("bp_load_rdy", in_ready, 4'b0010);
        q4.push_back({2'd1, 8'h3C});
        step();
        out_ready = 1'b0;
        in_valid = 4'b1111;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        repeat (5) begin
            #1;
            chk("bp_rdy", in_ready, 4'b0000);
            chk("bp_data", out_data, 8'h3C);
            chk("bp_valid", out_valid, 1);
            step();
        end
        out_ready = 1'b1;
        #1;
        s = RR ? 2 : 0;
        chk("bp_release_rdy", in_ready, 4'b1 << s);
        q4.push_back({2'(s), 8'(8'h10 + s)});
        step();
        in_valid = 4'b0000;
        #1;
        chk("bp_release_sel", out_sel, s);
        step();
        #1;
        chk("bp_drain", out_valid, 0);
        // Reset in the middle of a stall
        in_valid = 4'b0100;
        in_data[2*W +: W] = 8'h77;
        #1;
        chk("rs_load_rdy", in_ready, 4'b0100);
        q4.push_back({2'd2, 8'h77});
        step();
        in_valid = 4'b0000;
        out_ready = 1'b0;
        #1;
        chk("rs_hold1", out_data, 8'h77);
        step();
        #1;
        chk("rs_hold2", out_data, 8'h77);
        rst = 1'b1;
        q4.delete();
        in_valid = 4'b1111;
        in_data = {8'h13, 8'h12, 8'h11, 8'h10};
        #1;
        chk("rs_rdy", in_ready, 4'b0000);
        step();
        rst = 1'b0;
        #1;
        chk("rs_valid", out_valid, 0);
        chk("rs_data", out_data, 0);
        chk("rs_sel", out_sel, 0);
        out_ready = 1'b1;
        #1;
        chk("rs_restart_rdy", in_ready, 4'b0001);
        q4.push_back({2'd0, 8'h10});
        step();
        in_valid = 4'b0000;
        #1;
        step();
        #1;
        chk("rs_drain", out_valid, 0);
        // N=3: wrap from channel 2 back to 0
        v3 = 3'b100;
        #1;
        chk("n3_rdy_a", rdy3, 3'b100);
        q3.push_back({2'd2, 8'h22});
        step();
        v3 = 3'b011;
        #1;
        chk("n3_wrap_rdy", rdy3, 3'b001);
        q3.push_back({2'd0, 8'h20});
        step();
        v3 = 3'b101;
        #1;
        s = RR ? 2 : 0;
        chk("n3_rdy_c", rdy3, 3'b1 << s);
        q3.push_back({2'(s), 8'(8'h20 + s)});
        step();
        v3 = 3'b111;
        #1;
        chk("n3_rdy_d", rdy3, 3'b001);
        q3.push_back({2'd0, 8'h20});
        step();
        v3 = 3'b000;
        #1;
        step();
        #1;
        chk("n3_drain", ov3, 0);
        chk("q4_empty", q4.size(), 0);
        chk("q3_empty", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
